// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the integer clock divider.
package clk_div_pkg;

  localparam int unsigned NUM_RATIOS = 5;
  localparam int unsigned LEGAL_RATIOS [NUM_RATIOS] = '{2, 3, 4, 5, 8};

  // True when n is one of the supported divide ratios.
  function automatic bit is_legal_ratio(input int unsigned n);
    bit found;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_RATIOS; i++) begin
      if (LEGAL_RATIOS[i] == n) found = 1'b1;
    end
    return found;
  endfunction

  // Number of high cycles per period: ceil(n/2).
  function automatic int unsigned half_high(input int unsigned n);
    return (n + 32'd1) / 32'd2;
  endfunction

  // Phase counter width: ceil(log2(n)), at least one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 32'd2) ? 32'd1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/clk_div_phase_ctr.sv
// Modulo-N phase counter with a hold enable; resets to N-1 so the first
// edge after reset lands on phase 0.
module clk_div_phase_ctr
  import clk_div_pkg::*;
#(
  parameter int unsigned N = 5,
  parameter int unsigned W = cnt_width(N)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         hold_i,
  output logic [W-1:0] cnt_nxt_c_o
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next phase: hold, wrap at N-1, or increment.
  always_comb begin
    cnt_d = cnt_q;
    if (!hold_i) begin
      if (cnt_q == LAST) cnt_d = '0;
      else               cnt_d = cnt_q + W'(1);
    end
  end

  // Phase register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= LAST;
    else       cnt_q <= cnt_d;
  end

  assign cnt_nxt_c_o = cnt_d;

endmodule

// File: rtl/clk_div.sv
// Integer clock divider with single-cycle phase slip on each CALIB rising edge.
module clk_div
  import clk_div_pkg::*;
#(
  parameter int unsigned DIV_MODE = 5,
  parameter string       GSREN    = "false"
) (
  input  logic HCLKIN,
  input  logic RESET,
  input  logic CALIB,
  output logic CLKOUT
);

  localparam int unsigned N = DIV_MODE;
  localparam int unsigned H = half_high(N);
  localparam int unsigned W = cnt_width(N);

  // Reject unsupported ratios at elaboration rather than guessing one.
  if (!is_legal_ratio(N)) begin : g_bad_div_mode
    $error("clk_div: DIV_MODE=%0d is not one of 2,3,4,5,8", N);
  end

  // GSREN is accepted for drop-in compatibility only; flag typos.
  if (GSREN != "false" && GSREN != "true") begin : g_bad_gsren
    $warning("clk_div: GSREN should be \"true\" or \"false\"");
  end

  logic         calib_q;
  logic         calib_d;
  logic         calib_evt_c;
  logic         clkout_q;
  logic         clkout_d;
  logic [W-1:0] cnt_nxt;

  clk_div_phase_ctr #(
    .N (N),
    .W (W)
  ) u_phase_ctr (
    .clk_i       (HCLKIN),
    .rst_i       (RESET),
    .hold_i      (calib_evt_c),
    .cnt_nxt_c_o (cnt_nxt)
  );

  // CALIB edge detect and output decode from the counter's next phase.
  always_comb begin
    calib_d     = CALIB;
    calib_evt_c = CALIB & ~calib_q;
    clkout_d    = (cnt_nxt < W'(H));
    if (calib_evt_c) clkout_d = clkout_q;
  end

  // Output and CALIB history registers; reset forces low output, no pending event.
  always_ff @(posedge HCLKIN or posedge RESET) begin
    if (RESET) begin
      calib_q  <= 1'b1;
      clkout_q <= 1'b0;
    end else begin
      calib_q  <= calib_d;
      clkout_q <= clkout_d;
    end
  end

  assign CLKOUT = clkout_q;

endmodule

// File: tb/tb_clk_div.sv
// Directed bench for clk_div: table of CALIB/expected CLKOUT vectors on an
// N=5 instance, async reset sequence, and long free-run of all legal ratios.
module tb_clk_div;

  logic HCLKIN = 1'b0;
  logic RESET;
  logic CALIB;
  logic calib_hi;
  logic clk5, clk2, clk3, clk4, clk8, clk5g;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic calib;
    logic exp;
  } vec_t;

  vec_t vecs [21];

  always #5 HCLKIN = ~HCLKIN;

  clk_div #(.DIV_MODE(5)) dut5 (.HCLKIN(HCLKIN), .RESET(RESET), .CALIB(CALIB),    .CLKOUT(clk5));
  clk_div #(.DIV_MODE(2)) dut2 (.HCLKIN(HCLKIN), .RESET(RESET), .CALIB(calib_hi), .CLKOUT(clk2));
  clk_div #(.DIV_MODE(3)) dut3 (.HCLKIN(HCLKIN), .RESET(RESET), .CALIB(calib_hi), .CLKOUT(clk3));
  clk_div #(.DIV_MODE(4)) dut4 (.HCLKIN(HCLKIN), .RESET(RESET), .CALIB(calib_hi), .CLKOUT(clk4));
  clk_div #(.DIV_MODE(8)) dut8 (.HCLKIN(HCLKIN), .RESET(RESET), .CALIB(calib_hi), .CLKOUT(clk8));
  clk_div #(.DIV_MODE(5), .GSREN("true")) dut5g (.HCLKIN(HCLKIN), .RESET(RESET), .CALIB(calib_hi), .CLKOUT(clk5g));

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  // Golden waveform: k-th edge after release, no slips.
  function automatic logic golden(input int n, input int k);
    return (((k - 1) % n) < ((n + 1) / 2));
  endfunction

  initial begin
    // N=5 vectors: CALIB before the edge, CLKOUT after it.
    vecs[0]  = '{calib: 1'b1, exp: 1'b1}; // phase 0
    vecs[1]  = '{calib: 1'b1, exp: 1'b1}; // 1
    vecs[2]  = '{calib: 1'b1, exp: 1'b1}; // 2
    vecs[3]  = '{calib: 1'b1, exp: 1'b0}; // 3
    vecs[4]  = '{calib: 1'b1, exp: 1'b0}; // 4
    vecs[5]  = '{calib: 1'b0, exp: 1'b1}; // 0, CALIB low x3
    vecs[6]  = '{calib: 1'b0, exp: 1'b1}; // 1
    vecs[7]  = '{calib: 1'b0, exp: 1'b1}; // 2
    vecs[8]  = '{calib: 1'b1, exp: 1'b1}; // event: hold at 2
    vecs[9]  = '{calib: 1'b1, exp: 1'b0}; // 3 (one period late)
    vecs[10] = '{calib: 1'b1, exp: 1'b0}; // 4
    vecs[11] = '{calib: 1'b1, exp: 1'b1}; // 0
    vecs[12] = '{calib: 1'b1, exp: 1'b1}; // 1
    vecs[13] = '{calib: 1'b1, exp: 1'b1}; // 2
    vecs[14] = '{calib: 1'b1, exp: 1'b0}; // 3
    vecs[15] = '{calib: 1'b0, exp: 1'b0}; // 4
    vecs[16] = '{calib: 1'b1, exp: 1'b0}; // event at wrap: hold at 4
    vecs[17] = '{calib: 1'b1, exp: 1'b1}; // wrap to 0 one edge late
    vecs[18] = '{calib: 1'b1, exp: 1'b1}; // 1
    vecs[19] = '{calib: 1'b1, exp: 1'b1}; // 2
    vecs[20] = '{calib: 1'b1, exp: 1'b0}; // 3

    RESET    = 1'b1;
    CALIB    = 1'b1;
    calib_hi = 1'b1;
    #1;
    check("reset_clk5", clk5, 1'b0);
    check("reset_clk2", clk2, 1'b0);
    check("reset_clk8", clk8, 1'b0);

    repeat (2) @(posedge HCLKIN);
    #1;
    check("reset_hold_clk5", clk5, 1'b0);
    @(negedge HCLKIN);
    RESET = 1'b0;

    for (int i = 0; i < 21; i++) begin
      CALIB = vecs[i].calib;
      @(posedge HCLKIN);
      #1;
      check($sformatf("vec%0d", i), clk5, vecs[i].exp);
      @(negedge HCLKIN);
    end

    // Reach the high phase, then assert reset between edges.
    CALIB = 1'b1;
    @(posedge HCLKIN);
    #1;
    check("pre_rst_ph4", clk5, 1'b0);
    @(negedge HCLKIN);
    @(posedge HCLKIN);
    #1;
    check("pre_rst_ph0", clk5, 1'b1);
    #1;
    RESET = 1'b1;
    #1;
    check("async_rst_clk5", clk5, 1'b0);
    check("async_rst_clk3", clk3, 1'b0);
    check("async_rst_clk5g", clk5g, 1'b0);
    @(negedge HCLKIN);
    @(posedge HCLKIN);
    #1;
    check("rst_held_clk5", clk5, 1'b0);
    @(negedge HCLKIN);
    RESET = 1'b0;

    // Free run with CALIB high: every ratio follows the golden waveform.
    for (int k = 1; k <= 1000; k++) begin
      @(posedge HCLKIN);
      #1;
      check($sformatf("run_n5_k%0d", k),  clk5,  golden(5, k));
      check($sformatf("run_n2_k%0d", k),  clk2,  golden(2, k));
      check($sformatf("run_n3_k%0d", k),  clk3,  golden(3, k));
      check($sformatf("run_n4_k%0d", k),  clk4,  golden(4, k));
      check($sformatf("run_n8_k%0d", k),  clk8,  golden(8, k));
      check($sformatf("run_n5g_k%0d", k), clk5g, golden(5, k));
      @(negedge HCLKIN);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
